ksa_engine: RTL
===============

KSA_ENGINE -- requirements
Module: ksa_engine

Interface
REQ-001 Parameter ADDR_W, default 8: address and data width; table depth N = 2**ADDR_W.
REQ-002 Parameter KEY_LEN, default 3: number of key elements, each ADDR_W bits; legal range 1..N.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a run; sampled only in IDLE and DONE.
REQ-006 key  input  ADDR_W*KEY_LEN  key; element 0 = most-significant ADDR_W bits; held stable while busy.
REQ-007 busy  output  1  high from the cycle after start is accepted until the final write completes.
REQ-008 done  output  1  high in DONE; cleared when a new start is accepted or on reset.
REQ-009 mem_addr  output  ADDR_W  registered S-RAM address.
REQ-010 mem_wdata  output  ADDR_W  registered S-RAM write data.
REQ-011 mem_wren  output  1  registered S-RAM write enable.
REQ-012 mem_rdata  input  ADDR_W  S-RAM read data; valid one cycle after the RAM samples mem_addr, so two cycles after mem_addr is registered.

Function
REQ-013 States: IDLE, INIT, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, DONE.
REQ-014 Start accepted in IDLE/DONE -> INIT with i=0, j=0, done=0.
REQ-015 INIT: one write per cycle, S[i]=i for i=0..N-1 (mem_addr=i, mem_wdata=i, mem_wren=1); after i=N-1 -> RD_I with i=0.
REQ-016 RD_I: mem_addr=i, mem_wren=0 -> WT_I.
REQ-017 WT_I: hold mem_addr -> RD_J.
REQ-018 RD_J: capture si=mem_rdata; j <= (j + si + key[i mod KEY_LEN]) mod N; mem_addr=new j -> WT_J.
REQ-019 WT_J: hold -> WR_I.
REQ-020 WR_I: capture sj=mem_rdata; write S[i]=sj -> WR_J.
REQ-021 WR_J: write S[j]=si; if i==N-1 -> DONE, else i+1 -> RD_I.
REQ-022 Arithmetic is modulo N (truncated to ADDR_W bits); the key index wraps from KEY_LEN-1 to 0 with no divider.
REQ-023 i==j: both writes target the same address with an unchanged value; no special case.
REQ-024 Latency from start to done: exactly N + 6N cycles (1792 for ADDR_W=8), plus one cycle for the transition into DONE.
REQ-025 start while busy is ignored; start in DONE restarts a full run.
REQ-026 mem_wren is high only in INIT, WR_I and WR_J.

Reset
REQ-027 rst in any state, including mid-run -> IDLE next edge; i, j, si, sj, mem_addr, mem_wdata = 0.
REQ-028 After rst: mem_wren=0, busy=0, done=0; no partial write is completed after rst is asserted.
REQ-029 rst has priority over start in the same cycle.

Configuration
REQ-030 Macro KSA_CYCLE_CNT_EN defined: adds output cycle_cnt [31:0], cleared on rst or accepted start, incremented each busy cycle, frozen in DONE.
REQ-031 Macro KSA_CYCLE_CNT_EN undefined: port cycle_cnt and its counter are absent; all other behaviour is identical.

Verification
REQ-032 ADDR_W=2, KEY_LEN=1, key=0, start -> final S = [0,2,3,1]; done after 28 busy cycles.
REQ-033 ADDR_W=8, KEY_LEN=3, key=24'h000249, start -> S matches a software RC4-KSA model at all 256 entries; cycle_cnt=1792 when the macro is defined.
REQ-034 rst asserted in WR_I at i=10 -> mem_wren=0, busy=0 next cycle; subsequent start -> run completes with correct S.
REQ-035 start pulsed during the swap phase at i=50 -> no effect; the run finishes with S unchanged versus an uninterrupted run.
REQ-036 Back-to-back: start in DONE with a new key -> done drops next cycle; second result matches the model for the new key.

Source files
------------

// File: rtl/ksa_engine.sv
// rtl/ksa_engine.sv - RC4 key-scheduling engine driving an external synchronous S-RAM
// Optional cycle counter output enabled by defining KSA_CYCLE_CNT_EN.
module ksa_engine #(
  parameter int ADDR_W  = 8,
  parameter int KEY_LEN = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W*KEY_LEN-1:0] key,
  output logic                      busy,
  output logic                      done,
`ifdef KSA_CYCLE_CNT_EN
  output logic [31:0]               cycle_cnt,
`endif
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [ADDR_W-1:0]         mem_wdata,
  output logic                      mem_wren,
  input  logic [ADDR_W-1:0]         mem_rdata
);

  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_RD_I, S_WT_I, S_RD_J, S_WT_J, S_WR_I, S_WR_J, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [ADDR_W-1:0] si_q, si_d;
  logic [KW-1:0]     kidx_q, kidx_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wren_q, mem_wren_d;
  logic [ADDR_W-1:0] key_sel;
  logic [ADDR_W-1:0] j_new;
  logic              start_acc;
  logic              busy_w;
`ifdef KSA_CYCLE_CNT_EN
  logic [31:0]       cnt_q, cnt_d;
`endif

  assign start_acc = start && (state_q == S_IDLE || state_q == S_DONE);
  assign busy_w    = (state_q != S_IDLE) && (state_q != S_DONE);

  // Key element picked by a wrapping index counter, so no modulo hardware is needed.
  always_comb begin
    key_sel = '0;
    for (int k = 0; k < KEY_LEN; k++) begin
      if (kidx_q == KW'(k)) key_sel = key[(KEY_LEN-1-k)*ADDR_W +: ADDR_W];
    end
  end

  assign j_new = j_q + mem_rdata + key_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      si_q        <= '0;
      kidx_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
`ifdef KSA_CYCLE_CNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      kidx_q      <= kidx_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
`ifdef KSA_CYCLE_CNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_INIT;
      S_INIT:         if (&i_q) state_d = S_RD_I;
      S_RD_I:         state_d = S_WT_I;
      S_WT_I:         state_d = S_RD_J;
      S_RD_J:         state_d = S_WT_J;
      S_WT_J:         state_d = S_WR_I;
      S_WR_I:         state_d = S_WR_J;
      S_WR_J:         state_d = (&i_q) ? S_DONE : S_RD_I;
      default:        state_d = S_IDLE;
    endcase
  end

  // Read data arrives two cycles after the address register is loaded,
  // hence the wait states between each address and its capture.
  always_comb begin
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    kidx_d      = kidx_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          i_d    = '0;
          j_d    = '0;
          kidx_d = '0;
        end
      end
      S_INIT: begin
        mem_addr_d  = i_q;
        mem_wdata_d = i_q;
        mem_wren_d  = 1'b1;
        i_d         = i_q + ADDR_W'(1);
      end
      S_RD_I: mem_addr_d = i_q;
      S_RD_J: begin
        si_d       = mem_rdata;
        j_d        = j_new;
        mem_addr_d = j_new;
      end
      S_WR_I: begin
        mem_addr_d  = i_q;
        mem_wdata_d = mem_rdata;
        mem_wren_d  = 1'b1;
      end
      S_WR_J: begin
        mem_addr_d  = j_q;
        mem_wdata_d = si_q;
        mem_wren_d  = 1'b1;
        i_d         = i_q + ADDR_W'(1);
        kidx_d      = (kidx_q == KW'(KEY_LEN-1)) ? '0 : kidx_q + KW'(1);
      end
      default: ;
    endcase
  end

`ifdef KSA_CYCLE_CNT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (start_acc)   cnt_d = '0;
    else if (busy_w) cnt_d = cnt_q + 32'd1;
  end
  assign cycle_cnt = cnt_q;
`endif

  assign busy      = busy_w;
  assign done      = (state_q == S_DONE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;

endmodule
